// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// A miss stalls the CPU, optionally writes the dirty victim back, fetches
// the new block and then replays the held request as a hit.
module dcache #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   read,
  input  logic [2:0]   write,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [NUM_BLOCKS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [NUM_BLOCKS];
  logic [127:0]       data_q [NUM_BLOCKS];
  logic [IDX_W-1:0]   missIdx_q;
  logic [TAG_W-1:0]   missTag_q;

  logic [IDX_W-1:0]   reqIdx;
  logic [TAG_W-1:0]   reqTag;
  logic [3:0]         offset;
  logic               storeEn, loadEn, anyEn, hit, writeHit, missStart;
  logic [127:0]       line, newLine;
  logic [7:0]         byteSel;
  logic [15:0]        halfSel;
  logic [31:0]        wordSel;

  assign reqIdx    = address[4 +: IDX_W];
  assign reqTag    = address[31 -: TAG_W];
  assign offset    = address[3:0];
  assign storeEn   = write[2];
  assign loadEn    = read[3] & ~write[2];
  assign anyEn     = storeEn | loadEn;
  assign line      = data_q[reqIdx];
  assign hit       = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
  assign writeHit  = (state_q == IDLE) && storeEn && hit;
  assign missStart = (state_q == IDLE) && anyEn && !hit;

  // Select the addressed byte/half/word and extend it according to funct3.
  always_comb begin
    byteSel  = line[{offset, 3'b000} +: 8];
    halfSel  = line[{offset[3:1], 4'b0000} +: 16];
    wordSel  = line[{offset[3:2], 5'b00000} +: 32];
    readdata = '0;
    case (read[2:0])
      3'b000:  readdata = {{24{byteSel[7]}}, byteSel};
      3'b001:  readdata = {{16{halfSel[15]}}, halfSel};
      3'b010:  readdata = wordSel;
      3'b100:  readdata = {24'h0, byteSel};
      3'b101:  readdata = {16'h0, halfSel};
      default: readdata = '0;
    endcase
  end

  // Merge right-aligned store data into a copy of the addressed line.
  always_comb begin
    newLine = line;
    case (write[1:0])
      2'b00:   newLine[{offset, 3'b000} +: 8]         = writedata[7:0];
      2'b01:   newLine[{offset[3:1], 4'b0000} +: 16]  = writedata[15:0];
      2'b10:   newLine[{offset[3:2], 5'b00000} +: 32] = writedata;
      default: newLine = line;
    endcase
  end

  // Miss-handling FSM next state and memory-side outputs; reset forces the stall low.
  always_comb begin
    state_d       = state_q;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {missTag_q, missIdx_q};
    mem_writedata = data_q[missIdx_q];
    case (state_q)
      IDLE: begin
        if (anyEn && !hit) begin
          busywait = 1'b1;
          state_d  = (valid_q[reqIdx] && dirty_q[reqIdx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        busywait    = 1'b1;
        mem_write   = 1'b1;
        mem_address = {tag_q[missIdx_q], missIdx_q};
        if (!mem_busywait) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        busywait = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) busywait = 1'b0;
  end

  // State, valid/dirty bits and the latched miss address, all cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      missIdx_q <= '0;
      missTag_q <= '0;
    end else begin
      state_q <= state_d;
      if (missStart) begin
        missIdx_q <= reqIdx;
        missTag_q <= reqTag;
      end
      if (state_q == UPDATE) begin
        valid_q[missIdx_q] <= 1'b1;
        dirty_q[missIdx_q] <= 1'b0;
      end else if (writeHit) begin
        dirty_q[reqIdx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: refill on UPDATE, byte-merge on a store hit.
  always_ff @(posedge clock) begin
    if (state_q == UPDATE) begin
      data_q[missIdx_q] <= mem_readdata;
      tag_q[missIdx_q]  <= missTag_q;
    end else if (writeHit) begin
      data_q[reqIdx] <= newLine;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: table of load/store vectors plus hand-written
// miss, eviction and mid-miss reset sequences against a latency-modelled memory.
module tb_dcache;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   read = '0;
  logic [2:0]   write = '0;
  logic [31:0]  address = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         busywait, mem_read, mem_write, mem_busywait;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata, mem_readdata;

  dcache #(.NUM_BLOCKS(8)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Main memory model: busy for memLat cycles per access, then completes.
  logic [127:0] memArr [0:255];
  logic         memInit = 1'b1;
  int           memLat = 2;
  int           memCnt = 0;

  assign mem_busywait = (mem_read || mem_write) && (memCnt < memLat);
  assign mem_readdata = memArr[mem_address[7:0]];

  // Memory contents and access counter; write-backs land on the completing edge.
  always @(posedge clock) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++)
        memArr[i] <= {8'hA5, 8'h00, 8'(i), 8'h03, 8'hA5, 8'h00, 8'(i), 8'h02,
                      8'hA5, 8'h00, 8'(i), 8'h01, 8'hA5, 8'h00, 8'(i), 8'h00};
      memArr[4] <= 128'h00FFEEDD_CCBBAA99_88776655_44332211;
      memCnt    <= 0;
    end else if (mem_read || mem_write) begin
      if (memCnt >= memLat) begin
        if (mem_write) memArr[mem_address[7:0]] <= mem_writedata;
        memCnt <= 0;
      end else begin
        memCnt <= memCnt + 1;
      end
    end else begin
      memCnt <= 0;
    end
  end

  typedef struct {
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
    logic        expMiss;
    logic        expWb;
  } vec_t;

  vec_t  sbQ[$];
  vec_t  vecs[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  logic         sawBusy, sawWb, sawRd, sawBoth;
  logic [27:0]  wbAddr, rdAddr;
  logic [127:0] wbData;

  function automatic vec_t mk(input logic [3:0] rd, input logic [2:0] wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic chk, input logic [31:0] exp,
                              input logic expMiss, input logic expWb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.chk = chk; v.exp = exp; v.expMiss = expMiss; v.expWb = expWb;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    @(posedge clock);
    #1;
    read      = v.rd;
    write     = v.wr;
    address   = v.addr;
    writedata = v.wd;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v);
    sbQ.push_back(v);
  endtask

  task automatic checkOutput(input string name);
    vec_t e;
    int   cyc;
    e = sbQ.pop_front();
    sawBusy = 0; sawWb = 0; sawRd = 0; sawBoth = 0;
    wbAddr = '0; rdAddr = '0; wbData = '0;
    cyc = 0;
    @(negedge clock);
    while (busywait && cyc < 100) begin
      sawBusy = 1;
      if (mem_write) begin sawWb = 1; wbAddr = mem_address; wbData = mem_writedata; end
      if (mem_read) begin sawRd = 1; rdAddr = mem_address; end
      if (mem_read && mem_write) sawBoth = 1;
      cyc++;
      @(negedge clock);
    end
    check({name, " timeout"}, {127'h0, busywait}, 128'h0);
    check({name, " miss"}, {127'h0, sawBusy}, {127'h0, e.expMiss});
    check({name, " writeback"}, {127'h0, sawWb}, {127'h0, e.expWb});
    check({name, " rd/wr overlap"}, {127'h0, sawBoth}, 128'h0);
    if (e.chk) check({name, " data"}, {96'h0, readdata}, {96'h0, e.exp});
  endtask

  initial begin
    vec_t v;
    int   cyc;

    // Hit vectors applied after the first allocation of block 0x4.
    vecs.push_back(mk(4'b1000, 3'b000, 32'h47, 0, 1, 32'hFFFFFF88, 0, 0));
    vecs.push_back(mk(4'b1100, 3'b000, 32'h47, 0, 1, 32'h00000088, 0, 0));
    vecs.push_back(mk(4'b1001, 3'b000, 32'h46, 0, 1, 32'hFFFF8877, 0, 0));
    vecs.push_back(mk(4'b1101, 3'b000, 32'h46, 0, 1, 32'h00008877, 0, 0));
    vecs.push_back(mk(4'b1000, 3'b000, 32'h4B, 0, 1, 32'hFFFFFFCC, 0, 0));
    vecs.push_back(mk(4'b1100, 3'b000, 32'h4B, 0, 1, 32'h000000CC, 0, 0));
    vecs.push_back(mk(4'b1001, 3'b000, 32'h47, 0, 1, 32'hFFFF8877, 0, 0));
    vecs.push_back(mk(4'b1010, 3'b000, 32'h4E, 0, 1, 32'h00FFEEDD, 0, 0));
    vecs.push_back(mk(4'b1000, 3'b000, 32'h41, 0, 1, 32'h00000022, 0, 0));
    vecs.push_back(mk(4'b0000, 3'b110, 32'h44, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1010, 3'b000, 32'h44, 0, 1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(4'b0000, 3'b101, 32'h4D, 32'h1234ABCD, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1010, 3'b000, 32'h4C, 0, 1, 32'h00FFABCD, 0, 0));

    // Reset state.
    #1;
    check("reset busywait", {127'h0, busywait}, 128'h0);
    check("reset mem_read", {127'h0, mem_read}, 128'h0);
    check("reset mem_write", {127'h0, mem_write}, 128'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    memInit = 1'b0;
    @(negedge clock);
    check("idle busywait", {127'h0, busywait}, 128'h0);

    // First access after reset: allocate only, then word 0 of block 0x4.
    applyStimulus(mk(4'b1010, 3'b000, 32'h40, 0, 1, 32'h44332211, 1, 0));
    checkOutput("first LW 0x40");
    check("first alloc seen", {127'h0, sawRd}, {127'h0, 1'b1});
    check("first alloc addr", {100'h0, rdAddr}, {100'h0, 28'h0000004});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Same index, new tag: dirty victim written back, then block 0xC fetched.
    applyStimulus(mk(4'b1010, 3'b000, 32'hC4, 0, 1, 32'hA5000C01, 1, 1));
    checkOutput("evict LW 0xC4");
    check("evict wb addr", {100'h0, wbAddr}, {100'h0, 28'h0000004});
    check("evict wb data", wbData, 128'h00FFABCD_CCBBAA99_DEADBEEF_44332211);
    check("evict alloc seen", {127'h0, sawRd}, {127'h0, 1'b1});
    check("evict alloc addr", {100'h0, rdAddr}, {100'h0, 28'h000000C});

    // Dirty line 4 again, start a write-back miss and reset during its allocate.
    applyStimulus(mk(4'b0000, 3'b110, 32'hC8, 32'h12345678, 0, 0, 0, 0));
    checkOutput("SW 0xC8");
    v = mk(4'b1010, 3'b000, 32'h40, 0, 0, 0, 1, 1);
    driveInputs(v);
    sawWb = 0;
    cyc = 0;
    @(negedge clock);
    while (!mem_read && cyc < 100) begin
      if (mem_write) sawWb = 1;
      cyc++;
      @(negedge clock);
    end
    check("pre-reset writeback", {127'h0, sawWb}, {127'h0, 1'b1});
    check("pre-reset allocate", {127'h0, mem_read}, {127'h0, 1'b1});
    reset = 1'b1;
    #1;
    check("async reset mem_read", {127'h0, mem_read}, 128'h0);
    check("async reset busywait", {127'h0, busywait}, 128'h0);
    check("async reset mem_write", {127'h0, mem_write}, 128'h0);
    read = '0;
    write = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(mk(4'b1010, 3'b000, 32'hC4, 0, 1, 32'hA5000C01, 1, 0));
    checkOutput("post-reset LW 0xC4");
    applyStimulus(mk(4'b1010, 3'b000, 32'hC8, 0, 1, 32'h12345678, 0, 0));
    checkOutput("LW 0xC8 after wb");
    applyStimulus(mk(4'b1010, 3'b000, 32'h40, 0, 1, 32'h44332211, 1, 0));
    checkOutput("refetch LW 0x40");
    applyStimulus(mk(4'b1010, 3'b000, 32'h44, 0, 1, 32'hDEADBEEF, 0, 0));
    checkOutput("LW 0x44 from memory");

    // Both enables high: treated as SB.
    applyStimulus(mk(4'b1100, 3'b100, 32'h41, 32'h0000005A, 0, 0, 0, 0));
    checkOutput("SB both enables");
    applyStimulus(mk(4'b1100, 3'b000, 32'h41, 0, 1, 32'h0000005A, 0, 0));
    checkOutput("LBU 0x41");
    applyStimulus(mk(4'b1010, 3'b000, 32'h40, 0, 1, 32'h44335A11, 0, 0));
    checkOutput("LW 0x40 merged");

    @(posedge clock);
    #1;
    read = '0;
    write = '0;
    @(negedge clock);
    check("final idle busywait", {127'h0, busywait}, 128'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
